// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages.
// Holds default lane widths, the default frame length, and a saturating
// clamp helper used by the per-lane activation logic.
package cnn_pkg;

    // Default per-lane widths: accumulator input and activation output.
    localparam int unsigned CNN_DATA_W    = 30;
    localparam int unsigned CNN_OUT_W     = 16;

    // Default number of beats per frame.
    localparam int unsigned CNN_FRAME_LEN = 64;

    // Working width for the clamp; wide enough for any DATA_W the stages use.
    localparam int unsigned CLAMP_W       = 64;

    // Clamp result: clipped value plus a flag that a bound was hit.
    typedef struct packed {
        logic                      sat;
        logic signed [CLAMP_W-1:0] val;
    } clamp_t;

    // Clip v into [lo, hi]; sat marks that either bound was applied.
    function automatic clamp_t sat_clamp(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        clamp_t r;
        r.sat = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (v < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/relu_lane.sv
// Combinational per-lane activation: rectify, requantise by an arithmetic
// right shift, then saturate to OUT_W bits.
//
// Build option: LEAKY_RELU_EN
//   undefined - ReLU, unsigned output in [0, 2^OUT_W-1]
//   defined   - leaky ReLU (negative inputs scaled by 2^-LEAK_SHIFT),
//               two's-complement output in [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//
// Ports:
//   x      in   DATA_W  signed accumulator value
//   y_c    out  OUT_W   activated, requantised, clamped value
//   sat_c  out  1       set when the clamp was applied
module relu_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W     = CNN_DATA_W,
    parameter int unsigned OUT_W      = CNN_OUT_W,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic signed [DATA_W-1:0] x,
    output logic        [OUT_W-1:0]  y_c,
    output logic                     sat_c
);

    logic signed [CLAMP_W-1:0] x_w;
    logic signed [CLAMP_W-1:0] rect_w;
    logic signed [CLAMP_W-1:0] shift_w;
    clamp_t                    res;
    logic                      unused_hi;

    // Sign-extend into the wide working format.
    assign x_w = CLAMP_W'(x);

`ifdef LEAKY_RELU_EN
    localparam logic signed [CLAMP_W-1:0] LO = -(64'sd1 <<< (OUT_W - 1));
    localparam logic signed [CLAMP_W-1:0] HI = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;

    // Negative values keep a small slope; the shift floors toward -inf.
    assign rect_w = (x_w >= 64'sd0) ? x_w : (x_w >>> LEAK_SHIFT);
`else
    localparam logic signed [CLAMP_W-1:0] LO = 64'sd0;
    localparam logic signed [CLAMP_W-1:0] HI = (64'sd1 <<< OUT_W) - 64'sd1;
    localparam int unsigned unused_leak_shift = LEAK_SHIFT;

    assign rect_w = (x_w > 64'sd0) ? x_w : '0;
`endif

    // Requantise: floor division by 2^SHIFT.
    assign shift_w = rect_w >>> SHIFT;

    assign res   = sat_clamp(shift_w, LO, HI);
    assign y_c   = res.val[OUT_W-1:0];
    assign sat_c = res.sat;

    // Upper bits are always sign/zero copies once clamped.
    assign unused_hi = ^res.val[CLAMP_W-1:OUT_W];

endmodule

// File: rtl/relu_stream.sv
// Streaming multi-lane ReLU stage with valid/ready handshake.
// Each accepted beat is activated per lane (relu_lane), tagged with an
// end-of-frame marker from a beat counter, and held in an output register
// backed by one skid register so the input side can use a registered ready.
//
// Build option: LEAKY_RELU_EN (selects leaky ReLU with signed output lanes).
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst_n      in   1            synchronous active-low reset
//   enable     in   1            0 blocks new input; buffered beats still drain
//   in_valid   in   1            input beat valid
//   in_ready   out  1            input beat accepted when in_valid && in_ready
//   in_data    in   LANES*DATA_W lane i at [i*DATA_W +: DATA_W], signed
//   out_valid  out  1            output beat valid
//   out_ready  in   1            downstream ready
//   out_data   out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]
//   out_sat    out  LANES        per-lane saturation flag
//   out_last   out  1            beat is the last of its frame
//   done_relu  out  1            one-cycle pulse after a last beat leaves
module relu_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W     = CNN_DATA_W,
    parameter int unsigned LANES      = 4,
    parameter int unsigned OUT_W      = CNN_OUT_W,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned FRAME_LEN  = CNN_FRAME_LEN,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    output logic                     out_last,
    output logic                     done_relu
);

    localparam int unsigned CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned DATA_O = LANES * OUT_W;
    // Beat layout: {last, sat[LANES], data[LANES*OUT_W]}
    localparam int unsigned BEAT_W = DATA_O + LANES + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

    logic [DATA_O-1:0] lane_data_c;
    logic [LANES-1:0]  lane_sat_c;
    logic [BEAT_W-1:0] new_beat_c;
    logic              accept_c;
    logic              drain_c;

    logic              out_valid_q, out_valid_d;
    logic [BEAT_W-1:0] out_beat_q,  out_beat_d;
    logic              skid_valid_q, skid_valid_d;
    logic [BEAT_W-1:0] skid_beat_q, skid_beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;

    // Per-lane activation datapath.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_lane #(
            .DATA_W     (DATA_W),
            .OUT_W      (OUT_W),
            .SHIFT      (SHIFT),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x     (in_data[i*DATA_W +: DATA_W]),
            .y_c   (lane_data_c[i*OUT_W +: OUT_W]),
            .sat_c (lane_sat_c[i])
        );
    end

    assign accept_c   = in_valid && in_ready_q;
    assign drain_c    = out_valid_q && out_ready;
    assign new_beat_c = {(cnt_q == CNT_MAX), lane_sat_c, lane_data_c};

    // Next-state: output/skid occupancy, frame counter, registered ready.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        cnt_d        = cnt_q;
        done_d       = drain_c && out_beat_q[BEAT_W-1];

        if (accept_c) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end

        if (!out_valid_q || drain_c) begin
            // Output slot frees up: oldest pending beat moves in first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = accept_c;
                if (accept_c) begin
                    skid_beat_d = new_beat_c;
                end
            end else if (accept_c) begin
                out_valid_d = 1'b1;
                out_beat_d  = new_beat_c;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            // Output stalled: park the beat in the skid register.
            skid_valid_d = 1'b1;
            skid_beat_d  = new_beat_c;
        end

        // Ready is offered only while the skid slot is guaranteed free.
        in_ready_d = enable && !skid_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            done_q       <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_beat_q[DATA_O-1:0];
    assign out_sat   = out_beat_q[DATA_O +: LANES];
    assign out_last  = out_beat_q[BEAT_W-1];
    assign done_relu = done_q;

endmodule

// File: tb/tb_relu_stream.sv
// Directed bench for relu_stream: table of lane vectors with hand-computed
// results, replayed through single-beat, backpressure, frame, enable and
// reset sequences. Expected beats are queued in order on acceptance and
// compared whenever out_valid is high.
module tb_relu_stream;

    localparam int unsigned LANES     = 4;
    localparam int unsigned DATA_W    = 30;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned FRAME_LEN = 64;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic [LANES*DATA_W-1:0] in_data = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic [LANES*OUT_W-1:0]  out_data;
    logic [LANES-1:0]        out_sat;
    logic                    out_last;
    logic                    done_relu;

    relu_stream #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .OUT_W      (OUT_W),
        .SHIFT      (8),
        .FRAME_LEN  (FRAME_LEN),
        .LEAK_SHIFT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_last  (out_last),
        .done_relu (done_relu)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] x;
        logic [3:0][15:0] y;
        logic [3:0]       sat;
    } vec_t;

    typedef struct packed {
        logic        last;
        logic [3:0]  sat;
        logic [63:0] data;
    } exp_t;

    vec_t tbl [8];
    int   nv = 0;

    exp_t q[$];
    exp_t prev_out;
    int   checks = 0;
    int   errors = 0;
    int   m_cnt = 0;
    int   n_acc = 0;
    int   done_seen = 0;
    int   last_seen = 0;
    bit   exp_done = 1'b0;
    bit   stalled_prev = 1'b0;
    bit   ready_low_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int idx, input int x0, input int x1, input int x2, input int x3,
                           input int y0, input int y1, input int y2, input int y3,
                           input logic [3:0] s);
        tbl[idx].x[0] = x0;
        tbl[idx].x[1] = x1;
        tbl[idx].x[2] = x2;
        tbl[idx].x[3] = x3;
        tbl[idx].y[0] = 16'(y0);
        tbl[idx].y[1] = 16'(y1);
        tbl[idx].y[2] = 16'(y2);
        tbl[idx].y[3] = 16'(y3);
        tbl[idx].sat  = s;
    endtask

    function automatic logic [LANES*DATA_W-1:0] pack_in(input int vi);
        logic [LANES*DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            d[i*DATA_W +: DATA_W] = tbl[vi].x[i][DATA_W-1:0];
        end
        return d;
    endfunction

    // One clock: check outputs at this negedge, drive inputs, advance to next negedge.
    task automatic step(input bit v, input int vi, input bit ordy, input bit en);
        exp_t h;
        chk("done_relu", 64'(done_relu), 64'(exp_done));
        if (done_relu) done_seen++;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
                h = q[0];
                chk("out_data", out_data, h.data);
                chk("out_sat", 64'(out_sat), 64'(h.sat));
                chk("out_last", 64'(out_last), 64'(h.last));
            end
        end
        if (stalled_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_beat", 64'({out_last, out_sat, out_data}), 64'(prev_out));
        end
        enable    = en;
        out_ready = ordy;
        in_valid  = v;
        if (v) in_data = pack_in(vi);
        if (!in_ready) ready_low_seen = 1'b1;
        exp_done = 1'b0;
        if (out_valid && ordy) begin
            if (out_last) last_seen++;
            if (q.size() > 0) begin
                h = q.pop_front();
                exp_done = h.last;
            end
        end
        if (v && in_ready) begin
            h.data = tbl[vi].y;
            h.sat  = tbl[vi].sat;
            h.last = (m_cnt == FRAME_LEN - 1);
            q.push_back(h);
            m_cnt = (m_cnt == FRAME_LEN - 1) ? 0 : m_cnt + 1;
            n_acc++;
        end
        stalled_prev  = out_valid && !ordy;
        prev_out.last = out_last;
        prev_out.sat  = out_sat;
        prev_out.data = out_data;
        @(negedge clk);
    endtask

    task automatic send_n(input int n, input int budget);
        int start;
        int c;
        start = n_acc;
        c = 0;
        while ((n_acc - start) < n && c < budget) begin
            step(1'b1, (n_acc - start) % nv, 1'b1, 1'b1);
            c++;
        end
        chk("send_accepts", 64'(n_acc - start), 64'(n));
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b1);
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_done", 64'(done_relu), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        m_cnt        = 0;
        exp_done     = 1'b0;
        stalled_prev = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int c;
        int start;
`ifdef LEAKY_RELU_EN
        set_vec(0, -204800, -536870912, 512, 536870911, -100, -32768, 2, 32767, 4'b1010);
        set_vec(1, -8, -1, 0, 256, -1, -1, 0, 1, 4'b0000);
        set_vec(2, 8388607, 8388608, -67108864, -67108872, 32767, 32767, -32768, -32768, 4'b1010);
        set_vec(3, 74565, -2048, 0, -1, 291, -1, 0, -1, 4'b0000);
        nv = 4;
`else
        set_vec(0, 74565, -5, 0, 268435456, 291, 0, 0, 65535, 4'b1000);
        set_vec(1, 255, 256, -1, -536870912, 0, 1, 0, 0, 4'b0000);
        set_vec(2, 16777215, 16777216, 536870911, 511, 65535, 65535, 65535, 1, 4'b0110);
        set_vec(3, 12345678, 256000, -100000, 8, 48225, 1000, 0, 0, 4'b0000);
        set_vec(4, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        set_vec(5, 300000, 65280, 131072, -1, 1171, 255, 512, 0, 4'b0000);
        nv = 6;
`endif
        @(negedge clk);
        do_reset();

        // Single beats: one-cycle latency, table values.
        for (int vi = 0; vi < nv; vi++) begin
            step(1'b1, vi, 1'b1, 1'b1);
            chk("latency_out_valid", 64'(out_valid), 64'd1);
        end
        drain();

        // Backpressure: out_ready low for cycles 3..6 of a 10-beat stream.
        ready_low_seen = 1'b0;
        start = n_acc;
        c = 0;
        while ((n_acc - start) < 10 && c < 40) begin
            step(1'b1, (n_acc - start) % nv, !(c >= 3 && c <= 6), 1'b1);
            c++;
        end
        chk("bp_accepts", 64'(n_acc - start), 64'd10);
        drain();
        chk("bp_ready_dropped", 64'(ready_low_seen), 64'd1);

        // Frame boundary: 130 back-to-back beats give two last tags and two done pulses.
        do_reset();
        done_seen = 0;
        last_seen = 0;
        send_n(130, 300);
        drain();
        chk("frame_done_count", 64'(done_seen), 64'd2);
        chk("frame_last_count", 64'(last_seen), 64'd2);

        // Enable low for 5 cycles mid-frame: ready drops, counter holds.
        do_reset();
        last_seen = 0;
        send_n(10, 40);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) chk("en_low_in_ready", 64'(in_ready), 64'd0);
            step(1'b1, k % nv, 1'b1, 1'b0);
        end
        send_n(60, 200);
        drain();
        chk("en_last_count", 64'(last_seen), 64'd1);

        // Reset mid-frame: data discarded, next frame needs 64 fresh beats.
        do_reset();
        send_n(20, 60);
        do_reset();
        last_seen = 0;
        send_n(63, 200);
        drain();
        chk("rst_no_early_last", 64'(last_seen), 64'd0);
        send_n(1, 10);
        drain();
        chk("rst_last_after_64", 64'(last_seen), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/relu_stream.md
Name: relu_stream

Overview:
- Parametrised, multi-lane, streaming ReLU stage between a convolution/accumulate stage and the pooling or next-layer input.
- Each beat carries LANES signed accumulator values.
- Per lane: rectify, arithmetic right-shift requantisation, and saturation to OUT_W.
- Valid/ready handshake with a 2-entry skid buffer, a frame beat counter, and a done pulse at end of frame.

Parameters:
- DATA_W, 30, signed input width per lane
- LANES, 4, values per beat
- OUT_W, 16, output width per lane (unsigned; signed when LEAKY_RELU_EN is defined)
- SHIFT, 8, requantisation right shift, 0..DATA_W-1
- FRAME_LEN, 64, beats per frame (>=1); counter width clog2(FRAME_LEN), minimum 1
- LEAK_SHIFT, 3, negative-slope shift (used only when LEAKY_RELU_EN is defined)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  when 0, no new input is accepted; buffered data still drains
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], signed
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W]
- out_sat  out  LANES  per-lane saturation flag, aligned with out_data
- out_last  out  1  beat is frame index FRAME_LEN-1
- done_relu  out  1  one-cycle pulse when the last beat of a frame completes at the output

Behaviour:
- Reset (rst_n=0 at a clk edge) sets the following to 0: out_valid, out_data, out_sat, out_last, done_relu, in_ready, skid buffer, and beat counter. in_ready rises on the first edge after rst_n returns to 1.
- Lane function (per lane):
  - y = (x > 0) ? x : 0
  - z = y >>> SHIFT
  - if z > 2^OUT_W-1: out = 2^OUT_W-1, sat = 1; otherwise out = z[OUT_W-1:0], sat = 0
  - Zero input gives 0.
- Storage: one output register plus one skid register.
  - in_ready is registered: in_ready = enable && skid empty.
  - Accepted beat goes to the output register if it is empty or draining this cycle; otherwise it goes to skid.
  - Latency: 1 cycle from accept to out_valid with out_ready held high. Sustained throughput is 1 beat/cycle.
- Output hold: out_data, out_sat, and out_last stay stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Ordering: skid contents move to the output register on the drain cycle, preserving order.
- Beat counter: increments on input accept. At FRAME_LEN-1 it wraps to 0 and tags that beat last=1; the tag travels with the beat.
- done_relu: asserted for the cycle following the output handshake of a last=1 beat, then clears.
- enable=0 mid-frame: the counter holds its value; the frame resumes when enable returns to 1.
- Reset mid-frame: all data is discarded and the counter returns to 0.
- Simultaneous input accept and output drain with skid empty: the new beat goes directly to the output register.

Optional Feature:
- Macro: LEAKY_RELU_EN.
- Defined:
  - y = (x >= 0) ? x : x >>> LEAK_SHIFT
  - z = y >>> SHIFT (floor)
  - Clamp to signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat set on either bound.
  - out_data lanes are two's complement.
- Undefined: standard ReLU as specified above. LEAK_SHIFT is ignored.

Decomposition:
- Package cnn_pkg holds:
  - lane width defaults (DATA_W=30, OUT_W=16)
  - a saturating-clamp function
  - the default FRAME_LEN
- One sub-module: relu_lane, the combinational per-lane rectify/shift/clamp, instantiated LANES times via generate.
- Handshake, skid buffer, and counter live in relu_stream.

Test Plan:
- Basic lanes: reset, then one beat with lanes {74565, -5, 0, 268435456}, out_ready=1 → next cycle out_valid=1, lanes {291, 0, 0, 65535}, out_sat=4'b1000.
- Backpressure: stream 10 beats with out_ready low for cycles 3-6 → in_ready falls after the skid fills; all 10 beats come out in order, unchanged while stalled; none are lost.
- Frame end: FRAME_LEN=64, 130 consecutive beats → out_last on output beats 63 and 127; done_relu pulses exactly twice, each one cycle after the tagged handshake.
- Reset/enable: enable=0 for 5 cycles mid-frame → in_ready=0 and the counter holds. Separately, rst_n=0 at beat 20 → all outputs are 0 next cycle and the next frame's last appears after 64 new beats.
- Leaky (LEAKY_RELU_EN defined): lanes {-204800, -2^29, 512, 2^29-1} → {-100, -32768 with sat=1, 2, 32767 with sat=1}.
